// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared FSM encoding and bus polarity constants for cpu_bus_ctrl
// Purpose: state encoding for the bus master FSM and the 6502-style R/W polarity.
//   IDLE, ADDR, WAIT, DATA : core access phases (WAIT/DATA are shared with DMA)
//   DMA_RD, DMA_WR         : address phase of a DMA read / DMA write half
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WAIT   = 3'd2,
        DATA   = 3'd3,
        DMA_RD = 3'd4,
        DMA_WR = 3'd5
    } state_t;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

endpackage

// File: rtl/cpu_bus_dma.sv
// rtl/cpu_bus_dma.sv - sprite DMA page/index tracking and source address generation
// Purpose: holds the DMA page and byte index, and presents the source address of
//   the next DMA read to the bus master.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_start      : pulse, load page from i_page and restart the index at 0
//   i_page       : source page (high byte of the source address)
//   i_step       : pulse, one read/write pair finished
//   o_src        : source address for the next read (first read while i_start is high)
//   o_last       : the pair in flight is the final one of the burst
module cpu_bus_dma
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DMA_LEN = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_page,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_src,
    output logic              o_last
);

    localparam int CNT_W = $clog2(DMA_LEN + 1);

    logic [7:0]       r_page;
    logic [CNT_W-1:0] r_idx;
    logic [15:0]      w_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_page <= 8'h00;
            r_idx  <= '0;
        end else if (i_start) begin
            r_page <= i_page;
            r_idx  <= '0;
        end else if (i_step) begin
            r_idx  <= r_idx + CNT_W'(1);
        end
    end

    // The master loads bus_addr on the same edge that starts or steps the burst,
    // so the address offered is one ahead of the registered index.
    assign w_next = i_start ? {i_page, 8'h00}
                            : {r_page, 8'h00} + 16'(r_idx) + 16'd1;
    assign o_src  = ADDR_W'(w_next);
    assign o_last = (r_idx == CNT_W'(DMA_LEN - 1));

endmodule

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - CPU core to system bus master with wait states, RDY stretch and optional OAM DMA
// Purpose: turns level-held core requests into ADDR/WAIT/DATA bus accesses.
//   Optional sprite DMA engine enabled by macro CPU_BUS_DMA_EN.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_core_req/we/addr/wdata : core request (held until o_core_ack)
//   o_core_ack, o_core_rdata : completion pulse, read data (held until next read)
//   o_bus_addr, o_bus_rw  : bus address, 1=read 0=write
//   o_bus_dout, o_bus_oe  : write data and its output enable
//   i_bus_din, i_bus_rdy  : read data, 0 stretches DATA
//   o_dma_active          : DMA owns the bus
module cpu_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter int                WAIT_CYC = 1,
    parameter logic [ADDR_W-1:0] DMA_TRIG = ADDR_W'(16'h4014),
    parameter logic [ADDR_W-1:0] DMA_DST  = ADDR_W'(16'h2004),
    parameter int                DMA_LEN  = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_ack,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_rw,
    output logic [DATA_W-1:0] o_bus_dout,
    output logic              o_bus_oe,
    input  logic [DATA_W-1:0] i_bus_din,
    input  logic              i_bus_rdy,
    output logic              o_dma_active
);

    // Configuration sanity checks
    if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
        $error("WAIT_CYC must be 0..15");
    end
    if (DMA_LEN < 1 || DMA_LEN > 256) begin : g_bad_len
        $error("DMA_LEN must be 1..256");
    end
    if (DMA_TRIG == DMA_DST) begin : g_bad_dst
        $error("DMA_DST must differ from DMA_TRIG");
    end

    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYC - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              r_bus_rw;
    logic [DATA_W-1:0] r_bus_dout;
    logic              r_bus_oe;
    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic [3:0]        r_wait_cnt;
    logic              r_dma_active;

    logic              w_done;
    logic              w_dma_start;
    logic              w_dma_last;
    logic [ADDR_W-1:0] w_dma_src;

    assign w_done = (r_state == DATA) && i_bus_rdy;

`ifdef CPU_BUS_DMA_EN
    logic w_dma_step;

    // The trigger write is a normal core write; the burst starts as it completes.
    assign w_dma_start = w_done && !r_dma_active && (r_bus_rw == BUS_WRITE)
                         && (r_bus_addr == DMA_TRIG);
    assign w_dma_step  = w_done && r_dma_active && (r_bus_rw == BUS_WRITE);

    cpu_bus_dma #(
        .ADDR_W  (ADDR_W),
        .DMA_LEN (DMA_LEN)
    ) u_dma (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_dma_start),
        .i_page  (r_bus_dout[7:0]),
        .i_step  (w_dma_step),
        .o_src   (w_dma_src),
        .o_last  (w_dma_last)
    );
`else
    assign w_dma_start = 1'b0;
    assign w_dma_last  = 1'b0;
    assign w_dma_src   = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_bus_addr   <= '0;
            r_bus_rw     <= BUS_READ;
            r_bus_dout   <= '0;
            r_bus_oe     <= 1'b0;
            r_ack        <= 1'b0;
            r_rdata      <= '0;
            r_wait_cnt   <= 4'd0;
            r_dma_active <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Core is held off while DMA owns the bus: DMA never returns to IDLE mid-burst.
                    if (i_core_req) begin
                        r_state    <= ADDR;
                        r_bus_addr <= i_core_addr;
                        r_bus_rw   <= i_core_we ? BUS_WRITE : BUS_READ;
                        r_bus_dout <= i_core_wdata;
                    end
                end
                ADDR, DMA_RD, DMA_WR: begin
                    r_bus_oe <= (r_bus_rw == BUS_WRITE);
                    if (WAIT_CYC > 0) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= WAIT_M1;
                    end else begin
                        r_state    <= DATA;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= DATA;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                DATA: begin
                    if (i_bus_rdy) begin
                        r_bus_oe <= 1'b0;
                        if (r_dma_active) begin
                            if (r_bus_rw == BUS_READ) begin
                                // Read half done: forward the byte straight into the write half.
                                r_state    <= DMA_WR;
                                r_bus_addr <= DMA_DST;
                                r_bus_rw   <= BUS_WRITE;
                                r_bus_dout <= i_bus_din;
                            end else if (w_dma_last) begin
                                r_state      <= IDLE;
                                r_bus_rw     <= BUS_READ;
                                r_dma_active <= 1'b0;
                            end else begin
                                r_state    <= DMA_RD;
                                r_bus_addr <= w_dma_src;
                                r_bus_rw   <= BUS_READ;
                            end
                        end else begin
                            r_ack    <= 1'b1;
                            r_bus_rw <= BUS_READ;
                            if (r_bus_rw == BUS_READ) begin
                                r_rdata <= i_bus_din;
                            end
                            if (w_dma_start) begin
                                r_state      <= DMA_RD;
                                r_bus_addr   <= w_dma_src;
                                r_dma_active <= 1'b1;
                            end else begin
                                r_state      <= IDLE;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_core_ack   = r_ack;
    assign o_core_rdata = r_rdata;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_rw     = r_bus_rw;
    assign o_bus_dout   = r_bus_dout;
    assign o_bus_oe     = r_bus_oe;
    assign o_dma_active = r_dma_active;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - directed self-checking bench for cpu_bus_ctrl
module tb_cpu_bus_ctrl;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int WAIT_CYC = 1;
    localparam int DMA_LEN  = 256;
    localparam int ACC      = 2 + WAIT_CYC;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_we, core_ack;
    logic [ADDR_W-1:0] core_addr, bus_addr;
    logic [DATA_W-1:0] core_wdata, core_rdata, bus_dout, bus_din;
    logic              bus_rw, bus_oe, bus_rdy, dma_active;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: each address returns lo ^ hi ^ 0x87 (0x0123 -> 0xA5).
    assign bus_din = bus_addr[7:0] ^ bus_addr[15:8] ^ 8'h87;

    cpu_bus_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC), .DMA_LEN(DMA_LEN)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
        .i_core_wdata(core_wdata), .o_core_ack(core_ack), .o_core_rdata(core_rdata),
        .o_bus_addr(bus_addr), .o_bus_rw(bus_rw), .o_bus_dout(bus_dout), .o_bus_oe(bus_oe),
        .i_bus_din(bus_din), .i_bus_rdy(bus_rdy), .o_dma_active(dma_active)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({bus_addr, bus_rw, bus_dout, bus_oe} !== {16'h0000, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h rw=%b dout=%h oe=%b, expected 0000/1/00/0", bus_addr, bus_rw, bus_dout, bus_oe);
        end
        n_checks++;
        if ({core_ack, core_rdata, dma_active} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_core: ack=%b rdata=%h dma=%b, expected 0/00/0", core_ack, core_rdata, dma_active);
        end
        rst = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus_addr, bus_rw, bus_oe, core_ack} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_after_reset: addr=%h rw=%b oe=%b ack=%b, expected 0000/1/0/0", bus_addr, bus_rw, bus_oe, core_ack);
        end
    endtask

    task automatic test_read();
        int ack_at = -1;
        int n_ack  = 0;
        core_we = 1'b0; core_addr = 16'h0123; core_wdata = 8'h00; bus_rdy = 1'b1; core_req = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) core_addr = 16'hFFFF;
            if (t <= ACC) begin
                n_checks++;
                if (bus_addr !== 16'h0123 || bus_rw !== 1'b1 || bus_oe !== 1'b0 || core_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_phase t=%0d: addr=%h rw=%b oe=%b ack=%b, expected 0123/1/0/0", t, bus_addr, bus_rw, bus_oe, core_ack);
                end
            end
            if (core_ack === 1'b1) begin
                n_ack++;
                if (ack_at < 0) ack_at = t;
                core_req = 1'b0;
            end
        end
        n_checks++;
        if (ack_at !== ACC + 1 || n_ack !== 1) begin
            n_fail++;
            $display("FAIL read_latency: ack at tick %0d count %0d, expected tick %0d count 1", ack_at, n_ack, ACC + 1);
        end
        n_checks++;
        if (core_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_data: rdata=%h, expected a5", core_rdata);
        end
    endtask

    task automatic test_write();
        int ack_at = -1;
        core_we = 1'b1; core_addr = 16'h0200; core_wdata = 8'h3C; core_req = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t <= ACC) begin
                n_checks++;
                if (bus_addr !== 16'h0200 || bus_rw !== 1'b0 || bus_oe !== (t >= 2) || bus_dout !== 8'h3C) begin
                    n_fail++;
                    $display("FAIL write_phase t=%0d: addr=%h rw=%b oe=%b dout=%h, expected 0200/0/%0d/3c", t, bus_addr, bus_rw, bus_oe, bus_dout, (t >= 2));
                end
            end
            if (core_ack === 1'b1 && ack_at < 0) begin
                ack_at = t;
                core_req = 1'b0;
                n_checks++;
                if (bus_oe !== 1'b0 || core_rdata !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL write_end: oe=%b rdata=%h, expected 0/a5", bus_oe, core_rdata);
                end
            end
        end
        n_checks++;
        if (ack_at !== ACC + 1) begin
            n_fail++;
            $display("FAIL write_latency: ack at tick %0d, expected %0d", ack_at, ACC + 1);
        end
    endtask

    task automatic test_rdy_stall();
        int ack_at = -1;
        core_we = 1'b0; core_addr = 16'h0345; bus_rdy = 1'b0; core_req = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == ACC + 4) bus_rdy = 1'b1;
            if (ack_at < 0 && core_ack !== 1'b1) begin
                n_checks++;
                if (bus_addr !== 16'h0345 || bus_rw !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_addr t=%0d: addr=%h rw=%b, expected 0345/1", t, bus_addr, bus_rw);
                end
            end
            if (core_ack === 1'b1 && ack_at < 0) begin
                ack_at = t;
                core_req = 1'b0;
            end
        end
        n_checks++;
        if (ack_at !== ACC + 5 || core_rdata !== 8'hC1) begin
            n_fail++;
            $display("FAIL stall_ack: tick %0d rdata %h, expected tick %0d rdata c1", ack_at, core_rdata, ACC + 5);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [3];
        logic [7:0]  exp_d [3];
        int          i = 0;
        int          n_ack = 0;
        addrs[0] = 16'h0010; addrs[1] = 16'h0011; addrs[2] = 16'h0012;
        exp_d[0] = 8'h97;    exp_d[1] = 8'h96;    exp_d[2] = 8'h95;
        core_we = 1'b0; core_addr = addrs[0]; core_req = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (core_ack === 1'b1) begin
                n_ack++;
                n_checks++;
                if (i > 2 || core_rdata !== exp_d[i] || t !== (i + 1) * (ACC + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_ack%0d: tick %0d rdata %h, expected tick %0d rdata %h", i, t, core_rdata, (i + 1) * (ACC + 1), exp_d[i % 3]);
                end
                i++;
                if (i < 3) core_addr = addrs[i];
                else core_req = 1'b0;
            end
        end
        n_checks++;
        if (n_ack !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: %0d acks, expected 3", n_ack);
        end
    endtask

    task automatic test_abort();
        int n_ack = 0;
        core_we = 1'b0; core_addr = 16'h0777; core_req = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_addr, bus_rw, bus_dout, bus_oe, core_ack, core_rdata, dma_active} !== {16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_reset: addr=%h rw=%b dout=%h oe=%b ack=%b rdata=%h dma=%b, expected reset values", bus_addr, bus_rw, bus_dout, bus_oe, core_ack, core_rdata, dma_active);
        end
        core_req = 1'b0;
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (core_ack === 1'b1 || bus_addr !== 16'h0000) n_ack++;
        end
        n_checks++;
        if (n_ack !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with activity, expected 0", n_ack);
        end
    endtask

`ifdef CPU_BUS_DMA_EN
    task automatic test_dma();
        int          ack_at = -1, core2_ack = -1, rise_at = -1, fall_at = -1;
        int          k = 0, wr = 0, active_cnt = 0;
        logic [15:0] prev_addr, exp_addr, src;
        logic        prev_rw, prev_oe;
        logic [7:0]  exp_dout;
        core_we = 1'b1; core_addr = 16'h4014; core_wdata = 8'h02; bus_rdy = 1'b1; core_req = 1'b1;
        prev_addr = bus_addr; prev_rw = bus_rw; prev_oe = bus_oe;
        for (int t = 1; t <= 2 * DMA_LEN * ACC + 40; t++) begin
            tick();
            if (dma_active === 1'b1) active_cnt++;
            if (dma_active === 1'b1 && rise_at < 0) rise_at = t;
            if (dma_active === 1'b0 && rise_at >= 0 && fall_at < 0) fall_at = t;
            if (dma_active === 1'b1 && (bus_addr !== prev_addr || bus_rw !== prev_rw)) begin
                exp_addr = k[0] ? 16'h2004 : 16'h0200 + 16'(k / 2);
                n_checks++;
                if (bus_addr !== exp_addr || bus_rw !== ~k[0]) begin
                    n_fail++;
                    $display("FAIL dma_seq%0d: addr=%h rw=%b, expected %h/%b", k, bus_addr, bus_rw, exp_addr, ~k[0]);
                end
                k++;
            end
            if (dma_active === 1'b1 && bus_oe === 1'b1 && prev_oe === 1'b0) begin
                src = 16'h0200 + 16'(wr);
                exp_dout = src[7:0] ^ src[15:8] ^ 8'h87;
                n_checks++;
                if (bus_dout !== exp_dout || bus_addr !== 16'h2004) begin
                    n_fail++;
                    $display("FAIL dma_wdata%0d: dout=%h addr=%h, expected %h/2004", wr, bus_dout, bus_addr, exp_dout);
                end
                wr++;
            end
            if (core_ack === 1'b1) begin
                if (ack_at < 0) begin
                    ack_at = t;
                    core_we = 1'b0;
                    core_addr = 16'h0400;
                end else begin
                    core2_ack = t;
                    core_req = 1'b0;
                end
            end
            prev_addr = bus_addr; prev_rw = bus_rw; prev_oe = bus_oe;
            if (core2_ack > 0) break;
        end
        n_checks++;
        if (ack_at !== ACC + 1 || rise_at !== ack_at) begin
            n_fail++;
            $display("FAIL dma_trigger: ack tick %0d dma rise tick %0d, expected both %0d", ack_at, rise_at, ACC + 1);
        end
        n_checks++;
        if (k !== 2 * DMA_LEN || wr !== DMA_LEN || active_cnt !== 2 * DMA_LEN * ACC) begin
            n_fail++;
            $display("FAIL dma_counts: halves=%0d writes=%0d active=%0d, expected %0d/%0d/%0d", k, wr, active_cnt, 2 * DMA_LEN, DMA_LEN, 2 * DMA_LEN * ACC);
        end
        n_checks++;
        if (core2_ack < 0 || fall_at < 0 || core2_ack !== fall_at + ACC + 1 || core_rdata !== 8'h83) begin
            n_fail++;
            $display("FAIL dma_holdoff: core ack tick %0d dma fall tick %0d rdata %h, expected ack at fall+%0d rdata 83", core2_ack, fall_at, core_rdata, ACC + 1);
        end
    endtask

    task automatic test_dma_reset();
        int          k = 0, busy = 0;
        logic        hit = 1'b0;
        logic [15:0] prev_addr;
        logic        prev_rw;
        core_we = 1'b1; core_addr = 16'h4014; core_wdata = 8'h03; core_req = 1'b1;
        prev_addr = bus_addr; prev_rw = bus_rw;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (core_ack === 1'b1) core_req = 1'b0;
            if (dma_active === 1'b1 && (bus_addr !== prev_addr || bus_rw !== prev_rw)) k++;
            prev_addr = bus_addr; prev_rw = bus_rw;
            if (k == 19) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit || bus_addr !== 16'h0309 || bus_rw !== 1'b1) begin
            n_fail++;
            $display("FAIL dma10_reach: reached=%b addr=%h rw=%b, expected 1/0309/1", hit, bus_addr, bus_rw);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_addr, bus_rw, bus_dout, bus_oe, core_ack, core_rdata, dma_active} !== {16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL dma_reset: addr=%h rw=%b dout=%h oe=%b ack=%b rdata=%h dma=%b, expected reset values", bus_addr, bus_rw, bus_dout, bus_oe, core_ack, core_rdata, dma_active);
        end
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus_addr !== 16'h0000 || bus_oe !== 1'b0 || bus_rw !== 1'b1 || dma_active !== 1'b0 || core_ack !== 1'b0) busy++;
        end
        n_checks++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL dma_no_resume: %0d cycles with bus activity, expected 0", busy);
        end
    endtask
`else
    task automatic test_no_dma();
        int ack_at = -1, busy = 0;
        core_we = 1'b1; core_addr = 16'h4014; core_wdata = 8'h02; bus_rdy = 1'b1; core_req = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (core_ack === 1'b1 && ack_at < 0) begin
                ack_at = t;
                core_req = 1'b0;
            end
            if (ack_at > 0 && (dma_active !== 1'b0 || bus_oe !== 1'b0 || bus_addr !== 16'h4014 || bus_rw !== 1'b1)) busy++;
        end
        n_checks++;
        if (ack_at !== ACC + 1) begin
            n_fail++;
            $display("FAIL trig_plain_ack: ack tick %0d, expected %0d", ack_at, ACC + 1);
        end
        n_checks++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL trig_plain_quiet: %0d cycles of activity after ack, expected 0", busy);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; bus_rdy = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_rdy_stall();
        test_back_to_back();
        test_abort();
`ifdef CPU_BUS_DMA_EN
        test_dma();
        test_dma_reset();
`else
        test_no_dma();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
